// File: rtl/tpu_pkg.sv
// Shared encodings and state type for the TPU host-side job sequencer.
package tpu_pkg;

  localparam int N_ELEM = 16;
  localparam int IDX_W  = $clog2(N_ELEM);

  localparam logic [1:0] MA_IDLE = 2'b00;
  localparam logic [1:0] MA_WR_A = 2'b01;
  localparam logic [1:0] MA_WR_W = 2'b10;
  localparam logic [1:0] MA_RD_P = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_A, S_LOAD_W, S_KICK, S_WAIT_HI,
    S_WAIT_LO, S_RD_ISSUE, S_RD_WAIT, S_RD_HOLD, S_DONE
  } job_state_t;

endpackage

// File: rtl/tpu_job_ctrl.sv
// Job sequencer for the 4x4 systolic core: loads A (and optionally W),
// kicks the core, waits for busy high/low, then streams 16 products out.
module tpu_job_ctrl
  import tpu_pkg::*;
#(
  parameter int RD_LAT  = 1,
  parameter int BUSY_TO = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_reuse_w,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       job_done,
  output logic       err_timeout,
  output logic [7:0] tpu_data_in,
  output logic [3:0] tpu_wr_addr,
  output logic [3:0] tpu_rd_addr,
  output logic [1:0] tpu_mem_acc,
  output logic       tpu_start,
  input  logic       tpu_busy,
  input  logic [7:0] tpu_data_out
);

  localparam int TW = $clog2(BUSY_TO + 1);
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ELEM - 1);

  job_state_t       r_state, w_state;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic [TW-1:0]    r_timer, w_timer;
  logic [LW-1:0]    r_lat, w_lat;
  logic             r_reuse_w, w_reuse_w;
  logic             r_err, w_err;
  logic             r_out_valid, w_out_valid;
  logic [7:0]       r_out_data, w_out_data;
  logic             r_out_last, w_out_last;
  logic [7:0]       r_data_in, w_data_in;
  logic [3:0]       r_wr_addr, w_wr_addr;
  logic [3:0]       r_rd_addr, w_rd_addr;
  logic [1:0]       r_mem_acc, w_mem_acc;
  logic             r_start, w_start;

  // Next-state, next-register and handshake outputs; every tpu_* pin is a
  // register whose next value is decided here, so it launches one edge late.
  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_timer     = r_timer;
    w_lat       = r_lat;
    w_reuse_w   = r_reuse_w;
    w_err       = r_err;
    w_out_valid = r_out_valid;
    w_out_data  = r_out_data;
    w_out_last  = r_out_last;
    w_data_in   = r_data_in;
    w_wr_addr   = r_wr_addr;
    w_rd_addr   = r_rd_addr;
    w_mem_acc   = MA_IDLE;
    w_start     = 1'b0;
    cmd_ready   = 1'b0;
    in_ready    = 1'b0;
    job_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_reuse_w = cmd_reuse_w;
          w_idx     = '0;
          w_err     = 1'b0;
          w_state   = S_LOAD_A;
        end
      end
      S_LOAD_A, S_LOAD_W: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_wr_addr = r_idx;
          w_data_in = in_data;
          w_mem_acc = (r_state == S_LOAD_A) ? MA_WR_A : MA_WR_W;
          if (r_idx == LAST) begin
            w_idx   = '0;
            w_state = (r_state == S_LOAD_A && !r_reuse_w) ? S_LOAD_W : S_KICK;
          end else begin
            w_idx = r_idx + 1'b1;
          end
        end
      end
      S_KICK: begin
        w_start = 1'b1;
        w_timer = '0;
        w_state = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (tpu_busy) begin
          w_state = S_WAIT_LO;
        end else if (r_timer == TW'(BUSY_TO - 1)) begin
          // core never acknowledged the start: abandon the job, no output
          w_err   = 1'b1;
          w_state = S_IDLE;
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end
      S_WAIT_LO: begin
        if (!tpu_busy) w_state = S_RD_ISSUE;
      end
      S_RD_ISSUE: begin
        w_rd_addr = r_idx;
        w_mem_acc = MA_RD_P;
        w_lat     = '0;
        w_state   = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (r_lat == LW'(RD_LAT - 1)) begin
          w_out_data  = tpu_data_out;
          w_out_valid = 1'b1;
          w_out_last  = (r_idx == LAST);
          w_state     = S_RD_HOLD;
        end else begin
          // keep the read access asserted until the data is captured
          w_lat     = r_lat + LW'(1);
          w_mem_acc = MA_RD_P;
        end
      end
      S_RD_HOLD: begin
        if (out_ready) begin
          w_out_valid = 1'b0;
          w_out_last  = 1'b0;
          if (r_idx == LAST) begin
            w_state = S_DONE;
          end else begin
            w_idx   = r_idx + 1'b1;
            w_state = S_RD_ISSUE;
          end
        end
      end
      S_DONE: begin
        job_done = 1'b1;
        w_state  = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_timer     <= '0;
      r_lat       <= '0;
      r_reuse_w   <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_data_in   <= '0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_mem_acc   <= MA_IDLE;
      r_start     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_idx       <= w_idx;
      r_timer     <= w_timer;
      r_lat       <= w_lat;
      r_reuse_w   <= w_reuse_w;
      r_err       <= w_err;
      r_out_valid <= w_out_valid;
      r_out_data  <= w_out_data;
      r_out_last  <= w_out_last;
      r_data_in   <= w_data_in;
      r_wr_addr   <= w_wr_addr;
      r_rd_addr   <= w_rd_addr;
      r_mem_acc   <= w_mem_acc;
      r_start     <= w_start;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign err_timeout = r_err;
  assign tpu_data_in = r_data_in;
  assign tpu_wr_addr = r_wr_addr;
  assign tpu_rd_addr = r_rd_addr;
  assign tpu_mem_acc = r_mem_acc;
  assign tpu_start   = r_start;

endmodule

// File: tb/tb_tpu_job_ctrl.sv
// Directed bench for tpu_job_ctrl with a behavioural 4x4 core model.
module tb_tpu_job_ctrl;
  import tpu_pkg::*;

  localparam int BUSY_TO = 8;
  localparam logic [63:0] RST_VEC = 64'h1_0000_0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_reuse_w = 1'b0;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] in_data = 8'h0;
  logic       out_valid, out_ready = 1'b0, out_last, job_done, err_timeout;
  logic [7:0] out_data, tpu_data_in, tpu_data_out;
  logic [3:0] tpu_wr_addr, tpu_rd_addr;
  logic [1:0] tpu_mem_acc;
  logic       tpu_start, tpu_busy;

  always #5 clk = ~clk;

  tpu_job_ctrl #(.RD_LAT(1), .BUSY_TO(BUSY_TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_reuse_w(cmd_reuse_w),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .job_done(job_done), .err_timeout(err_timeout),
    .tpu_data_in(tpu_data_in), .tpu_wr_addr(tpu_wr_addr), .tpu_rd_addr(tpu_rd_addr),
    .tpu_mem_acc(tpu_mem_acc), .tpu_start(tpu_start), .tpu_busy(tpu_busy),
    .tpu_data_out(tpu_data_out)
  );

  // core model: scratch memories, busy 2 cycles after start for 4 cycles
  logic [7:0]  ma[16], mw[16];
  logic [2:0]  c_dly, c_hold;
  logic [15:0] acc16;
  bit          never_busy = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      tpu_busy <= 1'b0; c_dly <= '0; c_hold <= '0;
      for (int i = 0; i < 16; i++) begin ma[i] <= '0; mw[i] <= '0; end
    end else begin
      if (tpu_mem_acc == MA_WR_A) ma[tpu_wr_addr] <= tpu_data_in;
      if (tpu_mem_acc == MA_WR_W) mw[tpu_wr_addr] <= tpu_data_in;
      if (tpu_start && !never_busy) c_dly <= 3'd2;
      else if (c_dly != 0) begin
        c_dly <= c_dly - 1'b1;
        if (c_dly == 1) begin tpu_busy <= 1'b1; c_hold <= 3'd4; end
      end else if (c_hold != 0) begin
        c_hold <= c_hold - 1'b1;
        if (c_hold == 1) tpu_busy <= 1'b0;
      end
    end
  end

  always_comb begin
    acc16 = '0;
    for (int k = 0; k < 4; k++)
      acc16 = acc16 + 16'(ma[{tpu_rd_addr[3:2], 2'(k)}]) * 16'(mw[{2'(k), tpu_rd_addr[1:0]}]);
    tpu_data_out = (tpu_mem_acc == MA_RD_P) ? acc16[7:0] : 8'h0;
  end

  // bench state
  logic [7:0] a_vec[16], w_vec[16];
  logic [7:0] gold1[16] = '{8'd7, 8'd14, 8'd21, 8'd28, 8'd9, 8'd18, 8'd27, 8'd36,
                            8'd8, 8'd16, 8'd24, 8'd32, 8'd10, 8'd20, 8'd30, 8'd40};
  int n_checks = 0, n_errs = 0;
  int cyc = 0, n_wr_a = 0, n_wr_w = 0, n_start = 0, last_wr = 0, start_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_p(input int i);
    logic [15:0] s = '0;
    for (int k = 0; k < 4; k++)
      s = s + 16'(a_vec[(i / 4) * 4 + k]) * 16'(w_vec[k * 4 + (i % 4)]);
    return s[7:0];
  endfunction

  function automatic logic [63:0] outs_vec();
    return {31'b0, cmd_ready, in_ready, out_valid, out_data, out_last, job_done,
            err_timeout, tpu_data_in, tpu_wr_addr, tpu_rd_addr, tpu_mem_acc, tpu_start};
  endfunction

  // advance to the next falling edge and watch the core-side pins
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (tpu_mem_acc == MA_WR_A) begin
      chk("wr_a_addr", 64'(tpu_wr_addr), 64'(n_wr_a % 16));
      chk("wr_a_data", 64'(tpu_data_in), 64'(a_vec[n_wr_a % 16]));
      n_wr_a++; last_wr = cyc;
    end
    if (tpu_mem_acc == MA_WR_W) begin
      chk("wr_w_addr", 64'(tpu_wr_addr), 64'(n_wr_w % 16));
      chk("wr_w_data", 64'(tpu_data_in), 64'(w_vec[n_wr_w % 16]));
      n_wr_w++; last_wr = cyc;
    end
    if (tpu_start) begin
      n_start++; start_cyc = cyc;
      chk("start_gap", 64'(cyc - last_wr), 64'd1);
    end
  endtask

  task automatic send_cmd(input bit reuse);
    int b = 0;
    tick();
    cmd_valid = 1'b1; cmd_reuse_w = reuse;
    while (!cmd_ready && b < 20) begin tick(); b++; end
    chk("cmd_acc", 64'(cmd_ready), 64'd1);
  endtask

  task automatic load(input bit reuse, input bit gappy);
    int n = reuse ? 16 : 32;
    int i = 0, b = 0;
    bit first = 1'b1;
    while (i < n && b < 400) begin
      tick(); b++;
      cmd_valid = 1'b0;
      if (first) begin chk("err_clr", 64'(err_timeout), 64'd0); first = 1'b0; end
      in_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = (i < 16) ? a_vec[i] : w_vec[(i - 16) % 16];
      if (in_valid && in_ready) i++;
    end
    chk("load_cnt", 64'(i), 64'(n));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic poke();
    int b = 0;
    while (!tpu_busy && b < 20) begin tick(); b++; end
    chk("busy_seen", 64'(tpu_busy), 64'd1);
    tick();
    cmd_valid = 1'b1; in_valid = 1'b1;
    chk("wl_cmd_rdy", 64'(cmd_ready), 64'd0);
    chk("wl_in_rdy", 64'(in_ready), 64'd0);
    tick();
    cmd_valid = 1'b0; in_valid = 1'b0;
  endtask

  task automatic read_out(input bit stall, input bit gold, input int abort_at);
    int got = 0, b = 0;
    bit pst = 1'b0;
    logic [7:0] pd = '0, e;
    while (got < 16 && b < 600) begin
      tick(); b++;
      if (pst) begin
        chk("hold_vld", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(pd));
      end
      if (out_valid && got == abort_at) begin
        out_ready = 1'b0; rst = 1'b1;
        tick();
        chk("rst_abort", outs_vec(), RST_VEC);
        rst = 1'b0;
        return;
      end
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) begin
        if (out_ready) begin
          e = gold ? gold1[got] : exp_p(got);
          chk("out_data", 64'(out_data), 64'(e));
          chk("out_last", 64'(out_last), 64'(got == 15));
          got++; pst = 1'b0;
        end else begin
          pst = 1'b1; pd = out_data;
        end
      end else pst = 1'b0;
    end
    chk("read_cnt", 64'(got), 64'd16);
    tick();
    out_ready = 1'b0;
    chk("job_done", 64'(job_done), 64'd1);
    tick();
    chk("idle_rdy", 64'(cmd_ready), 64'd1);
    chk("done_pulse", 64'(job_done), 64'd0);
  endtask

  task automatic run_job(input bit reuse, input bit gappy, input bit stall,
                         input bit gold, input bit pk, input int abort_at);
    int wa0 = n_wr_a, ww0 = n_wr_w, s0 = n_start;
    send_cmd(reuse);
    load(reuse, gappy);
    if (pk) poke();
    read_out(stall, gold, abort_at);
    chk("n_wr_a", 64'(n_wr_a - wa0), 64'd16);
    chk("n_wr_w", 64'(n_wr_w - ww0), reuse ? 64'd0 : 64'd16);
    chk("n_start", 64'(n_start - s0), 64'd1);
  endtask

  initial begin
    int b;
    bit seen_ov;
    repeat (3) tick();
    chk("rst_outs", outs_vec(), RST_VEC);
    rst = 1'b0;

    // full job with the reference operands, WAIT_LO poke
    a_vec = '{8'd4, 8'd0, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd0,
              8'd4, 8'd3, 8'd0, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1};
    w_vec = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4,
              8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4};
    run_job(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16);

    // weight reuse with gappy input and output stalls
    a_vec = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd1, 8'd0, 8'd1,
              8'd5, 8'd0, 8'd0, 8'd2, 8'd1, 8'd1, 8'd1, 8'd1};
    run_job(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16);

    // core never goes busy
    never_busy = 1'b1;
    send_cmd(1'b0);
    load(1'b0, 1'b0);
    b = 0; seen_ov = 1'b0;
    while (!cmd_ready && b < 40) begin
      tick(); b++;
      if (out_valid) seen_ov = 1'b1;
    end
    chk("to_cyc", 64'(cyc - start_cyc), 64'(BUSY_TO));
    chk("to_err", 64'(err_timeout), 64'd1);
    chk("to_noout", 64'(seen_ov), 64'd0);
    never_busy = 1'b0;

    // recovery job with wrapping products
    a_vec = '{8'd200, 8'd10, 8'd0, 8'd1, 8'd3, 8'd250, 8'd7, 8'd0,
              8'd0, 8'd0, 8'd128, 8'd2, 8'd9, 8'd8, 8'd7, 8'd6};
    w_vec = '{8'd2, 8'd0, 8'd1, 8'd0, 8'd0, 8'd3, 8'd0, 8'd1,
              8'd1, 8'd0, 8'd2, 8'd0, 8'd0, 8'd1, 8'd0, 8'd3};
    run_job(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16);

    // reset during the eighth product, then a clean job
    run_job(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7);
    run_job(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
